pll_lock_supervisor: RTL and testbench

Runs in the rPLL output clock domain (90 MHz `clkout`). It takes the PLL's raw asynchronous `lock` and synchronizes it. It then qualifies it with a minimum hold and a continuous-stability interval, and only after that releases a synchronous reset to downstream spectrogram logic. It detects loss of lock once running, re-asserts reset, and keeps a saturating loss counter for debug/LED display.

---
 rtl/pll_lock_supervisor.sv | 112 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Qualifies the raw PLL lock signal and produces a clean downstream reset.
// It also flags a loss of lock while running and keeps a saturating count of losses.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STABLE_CYCLES = 90000,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  output logic                  lock_sync,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  loss_event,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int MAX_CYC = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    rst_out_q, rst_out_d;
  logic                    ready_q, ready_d;
  logic                    loss_event_q, loss_event_d;
  logic [LOSS_CNT_W-1:0]   loss_count_q, loss_count_d;
  logic                    lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], lock_in};
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_event_d = 1'b0;
    loss_count_d = loss_count_q;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Any low sample counts as a loss; a healthy PLL lock never glitches.
        if (!lock_s) begin
          state_d      = S_HOLD;
          cnt_d        = '0;
          loss_event_d = 1'b1;
          if (loss_count_q != '1) loss_count_d = loss_count_q + 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
    rst_out_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      sync_q       <= '0;
      rst_out_q    <= 1'b1;
      ready_q      <= 1'b0;
      loss_event_q <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      rst_out_q    <= rst_out_d;
      ready_q      <= ready_d;
      loss_event_q <= loss_event_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign lock_sync  = lock_s;
  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign loss_event = loss_event_q;
  assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with HOLD=4, STABLE=8, 2-bit loss counter.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b1;
  logic       lock_sync, rst_out, ready, loss_event;
  logic [1:0] loss_count;

  int total = 0;
  int bad   = 0;
  int rel_q[$];
  int loss_q[$];

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .HOLD_CYCLES(4), .STABLE_CYCLES(8), .LOSS_CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .lock_in(lock_in), .lock_sync(lock_sync),
    .rst_out(rst_out), .ready(ready), .loss_event(loss_event), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected edge count and measures edges until ready rises.
  task automatic wait_ready(input string tag);
    int n = 0;
    int exp = rel_q.pop_front();
    while (!ready && n < 200) begin
      step();
      n++;
      if (!ready) chk({tag, "_rst_out_hi"}, int'(rst_out), 1);
    end
    chk(tag, n, exp);
    chk({tag, "_rst_out_lo"}, int'(rst_out), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    chk("rst_rst_out", int'(rst_out), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_loss_cnt", int'(loss_count), 0);
    chk("rst_loss_evt", int'(loss_event), 0);
    chk("rst_sync", int'(lock_sync), 0);
    rst = 1'b0;
  endtask

  // Drop lock in RUN; the loss must show on the third edge, then relock takes 13 edges.
  task automatic lose(input int exp_cnt);
    lock_in = 1'b0;
    loss_q.push_back(exp_cnt);
    step();
    step();
    chk("loss_early_ready", int'(ready), 1);
    step();
    chk("loss_ready", int'(ready), 0);
    chk("loss_rst_out", int'(rst_out), 1);
    chk("loss_pulse", int'(loss_event), 1);
    lock_in = 1'b1;
    rel_q.push_back(13);
    wait_ready("relock");
  endtask

  always @(posedge clk) begin
    int e;
    #1;
    if (loss_event) begin
      if (loss_q.size() == 0) begin
        chk("loss_unexpected", 1, 0);
      end else begin
        e = loss_q.pop_front();
        chk("loss_count", int'(loss_count), e);
      end
    end
  end

  initial begin
    // Power-up with lock already high.
    lock_in = 1'b1;
    do_reset(3);
    rel_q.push_back(13);
    wait_ready("powerup");
    chk("powerup_loss_cnt", int'(loss_count), 0);

    // One-cycle lock glitch sampled at stable cnt=5: release at edge 20 instead of 13.
    do_reset(1);
    repeat (8) step();
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    rel_q.push_back(11);
    wait_ready("glitch");
    chk("glitch_loss_cnt", int'(loss_count), 0);

    // Two losses, then reset mid-run clears the counter.
    lose(1);
    lose(2);
    chk("pre_rst_loss_cnt", int'(loss_count), 2);
    do_reset(1);
    rel_q.push_back(13);
    wait_ready("after_rst");

    // Saturation: 1,2,3,3,3.
    for (int i = 1; i <= 5; i++) lose((i < 3) ? i : 3);
    chk("sat_loss_cnt", int'(loss_count), 3);

    // Lock never arrives.
    lock_in = 1'b0;
    do_reset(1);
    repeat (30) step();
    chk("nolock_rst_out", int'(rst_out), 1);
    chk("nolock_ready", int'(ready), 0);
    chk("nolock_loss_cnt", int'(loss_count), 0);
    lock_in = 1'b1;
    rel_q.push_back(11);
    wait_ready("late_lock");

    step();
    chk("loss_q_empty", loss_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
